// File: rtl/clint_host_pkg.sv
// clint_host_pkg: CLINT register offsets, request opcodes and sequencer
// states shared by clint_host and clint_bus_beat.
package clint_host_pkg;

    localparam logic [31:0] OFF_MSIP    = 32'h0000_0000;
    localparam logic [31:0] OFF_CMP_LO  = 32'h0000_4000;
    localparam logic [31:0] OFF_CMP_HI  = 32'h0000_4004;
    localparam logic [31:0] OFF_TIME_LO = 32'h0000_BFF8;
    localparam logic [31:0] OFF_TIME_HI = 32'h0000_BFFC;

    typedef enum logic [1:0] {
        OP_READ_TIME  = 2'b00,
        OP_WRITE_CMP  = 2'b01,
        OP_WRITE_MSIP = 2'b10,
        OP_RSVD       = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BEAT = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    // Time reads go hi, lo, hi; cmp writes go lo, hi, lo.
    function automatic logic [31:0] beat_offset(op_e op, logic [1:0] step);
        logic [31:0] off;
        off = OFF_MSIP;
        case (op)
            OP_READ_TIME: off = (step == 2'd1) ? OFF_TIME_LO : OFF_TIME_HI;
            OP_WRITE_CMP: off = (step == 2'd1) ? OFF_CMP_HI : OFF_CMP_LO;
            default:      off = OFF_MSIP;
        endcase
        return off;
    endfunction

endpackage

// File: rtl/clint_bus_beat.sv
// clint_bus_beat: one 32-bit valid/ready beat toward the CLINT.
// Optional per-beat watchdog enabled by CLINT_HOST_TIMEOUT_EN.
module clint_bus_beat
    import clint_host_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] addr,
    input  logic [3:0]  wmask,
    input  logic [31:0] wdata,
    output logic        done,
    output logic [31:0] rdata,
    output logic        timeout,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    assign done  = mem_valid && mem_ready;
    assign rdata = mem_rdata;

`ifdef CLINT_HOST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (reset || !mem_valid || mem_ready) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign timeout = mem_valid && !mem_ready &&
                     (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = (TIMEOUT_CYCLES < 0);
`endif

    // Valid drops on the completing edge, so the next cycle is the gap
    // that swallows the responder's stale registered ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wmask <= '0;
            mem_wdata <= '0;
        end else if (mem_valid) begin
            if (done || timeout) begin
                mem_valid <= 1'b0;
            end
        end else if (start) begin
            mem_valid <= 1'b1;
            mem_addr  <= addr;
            mem_wmask <= wmask;
            mem_wdata <= wdata;
        end
    end

endmodule

// File: rtl/clint_host.sv
// clint_host: sequences tear-free mtime reads and glitch-free mtimecmp writes
// as 32-bit beats. CLINT_HOST_TIMEOUT_EN enables the beat watchdog.
module clint_host
    import clint_host_pkg::*;
#(
    parameter logic [31:0] CLINT_BASE     = 32'h1100_0000,
    parameter int          MAX_RETRIES    = 3,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [1:0]  req_op,
    input  logic [63:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    state_e        state;
    op_e           op_q;
    logic [63:0]   wdata_q;
    logic [1:0]    step;
    logic [RW-1:0] retries;
    logic [31:0]   hi1;
    logic [31:0]   lo;

    op_e         cur_op;
    logic [1:0]  cur_step;
    logic [63:0] cur_wdata;
    logic        start;
    logic [31:0] beat_addr;
    logic [3:0]  beat_wmask;
    logic [31:0] beat_wdata;
    logic        done;
    logic        timeout;
    logic [31:0] rdata;

    // The first beat launches on the accept edge, before op_q is loaded.
    always_comb begin
        cur_op     = (state == S_IDLE) ? op_e'(req_op) : op_q;
        cur_step   = (state == S_IDLE) ? 2'd0 : step;
        cur_wdata  = (state == S_IDLE) ? req_wdata : wdata_q;
        start      = ((state == S_IDLE) && req_valid &&
                      (op_e'(req_op) != OP_RSVD)) || (state == S_GAP);
        beat_addr  = CLINT_BASE + beat_offset(cur_op, cur_step);
        beat_wmask = 4'h0;
        beat_wdata = 32'h0;
        case (cur_op)
            OP_WRITE_CMP: begin
                beat_wmask = 4'hF;
                case (cur_step)
                    2'd0:    beat_wdata = 32'hFFFF_FFFF;
                    2'd1:    beat_wdata = cur_wdata[63:32];
                    default: beat_wdata = cur_wdata[31:0];
                endcase
            end
            OP_WRITE_MSIP: begin
                beat_wmask = 4'b0001;
                beat_wdata = {31'b0, cur_wdata[0]};
            end
            default: ;
        endcase
    end

    clint_bus_beat #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_beat (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .addr      (beat_addr),
        .wmask     (beat_wmask),
        .wdata     (beat_wdata),
        .done      (done),
        .rdata     (rdata),
        .timeout   (timeout),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wmask (mem_wmask),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            op_q       <= OP_READ_TIME;
            wdata_q    <= '0;
            step       <= '0;
            retries    <= '0;
            hi1        <= '0;
            lo         <= '0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        op_q      <= op_e'(req_op);
                        wdata_q   <= req_wdata;
                        step      <= '0;
                        retries   <= '0;
                        req_ready <= 1'b0;
                        if (op_e'(req_op) == OP_RSVD) begin
                            state      <= S_DONE;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else begin
                            state <= S_BEAT;
                        end
                    end
                end
                S_BEAT: begin
                    if (timeout) begin
                        state      <= S_DONE;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                    end else if (done) begin
                        if (op_q == OP_READ_TIME) begin
                            if (step == 2'd0) begin
                                hi1   <= rdata;
                                step  <= 2'd1;
                                state <= S_GAP;
                            end else if (step == 2'd1) begin
                                lo    <= rdata;
                                step  <= 2'd2;
                                state <= S_GAP;
                            end else if (hi1 == rdata) begin
                                state      <= S_DONE;
                                resp_valid <= 1'b1;
                                resp_rdata <= {rdata, lo};
                            end else if (retries < RW'(MAX_RETRIES)) begin
                                // hi moved under us: re-read lo, then hi again
                                hi1     <= rdata;
                                retries <= retries + 1'b1;
                                step    <= 2'd1;
                                state   <= S_GAP;
                            end else begin
                                state      <= S_DONE;
                                resp_valid <= 1'b1;
                                resp_err   <= 1'b1;
                                resp_rdata <= {rdata, lo};
                            end
                        end else if (op_q == OP_WRITE_CMP && step != 2'd2) begin
                            step  <= step + 2'd1;
                            state <= S_GAP;
                        end else begin
                            state      <= S_DONE;
                            resp_valid <= 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    state <= S_BEAT;
                end
                S_DONE: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clint_host.sv
// tb_clint_host: randomized scoreboard bench for clint_host against a CLINT
// responder model and a request-level reference of the read/write rules.
`timescale 1ns/1ps
module tb_clint_host;

    localparam logic [31:0] BASE = 32'h1100_0000;
    localparam int          MAXR = 3;
    localparam logic [1:0]  OP_RT = 2'b00;
    localparam logic [1:0]  OP_CMP = 2'b01;
    localparam logic [1:0]  OP_MSIP = 2'b10;
    localparam logic [1:0]  OP_RSV = 2'b11;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [1:0]  req_op = 2'b00;
    logic [63:0] req_wdata = '0;
    logic        req_ready;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready = 1'b0;

    always #5 clk = ~clk;

    clint_host dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_valid  (mem_valid),
        .mem_addr   (mem_addr),
        .mem_wmask  (mem_wmask),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    int n_tests = 0;
    int n_fail = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // CLINT responder: registered ready, scripted mtime, mtimecmp store
    logic [31:0] hi_s [0:15];
    logic [31:0] lo_s [0:15];
    int          hi_i = 0;
    int          lo_i = 0;
    int          wait_pct = 0;
    bit          stuck = 1'b0;
    bit          clr = 1'b0;
    bit          irq_watch = 1'b0;
    logic [63:0] mtime_m = '0;
    logic [63:0] cmp_m = '1;
    int          irq_hits = 0;

    assign mem_rdata = (mem_addr == BASE + 32'hBFFC) ? hi_s[hi_i[3:0]]
                                                    : lo_s[lo_i[3:0]];

    always @(posedge clk) begin
        if (clr) begin
            hi_i     <= 0;
            lo_i     <= 0;
            cmp_m    <= '1;
            irq_hits <= 0;
        end else begin
            if (mem_valid && mem_ready) begin
                if (mem_wmask == 4'h0) begin
                    if (mem_addr == BASE + 32'hBFFC) hi_i <= hi_i + 1;
                    else lo_i <= lo_i + 1;
                end else if (mem_addr == BASE + 32'h4000) begin
                    cmp_m[31:0] <= mem_wdata;
                end else if (mem_addr == BASE + 32'h4004) begin
                    cmp_m[63:32] <= mem_wdata;
                end
            end
            if (irq_watch && mtime_m >= cmp_m) irq_hits <= irq_hits + 1;
        end
        mem_ready <= !stuck && mem_valid &&
                     (int'($urandom_range(99)) >= wait_pct);
    end

    // Scoreboard queues and monitor
    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } beat_t;

    resp_t rq[$];
    beat_t bq[$];
    resp_t mr;
    beat_t mb;
    int    cyc = 0;
    int    valid_cycles = 0;
    bit    prev_hs = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (prev_hs) check("gap_after_beat", mem_valid, 1'b0);
        prev_hs = mem_valid && mem_ready;
        if (mem_valid) valid_cycles++;
        if (mem_valid && mem_ready) begin
            if (bq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_beat: addr %0h, none expected", mem_addr);
            end else begin
                mb = bq.pop_front();
                check("beat_addr", mem_addr, mb.addr);
                check("beat_wmask", mem_wmask, mb.wmask);
                if (mb.wmask != 4'h0) check("beat_wdata", mem_wdata, mb.wdata);
            end
        end
        if (resp_valid) begin
            if (rq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_resp: rdata %0h, none expected", resp_rdata);
            end else begin
                mr = rq.pop_front();
                check("resp_rdata", resp_rdata, mr.rdata);
                check("resp_err", resp_err, mr.err);
                if (mr.lat >= 0) check("resp_latency", cyc - mr.acc + 1, mr.lat);
            end
        end
    end

    task automatic clr_model();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic issue(logic [1:0] op, logic [63:0] wd,
                         logic [63:0] er, logic ee, int el);
        int    t;
        resp_t r;
        t = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (req_ready !== 1'b1) check("req_ready_wait", req_ready, 1'b1);
        req_valid = 1'b1;
        req_op    = op;
        req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        r.rdata = er;
        r.err   = ee;
        r.lat   = el;
        r.acc   = cyc;
        rq.push_back(r);
    endtask

    task automatic drain(string name);
        int t;
        t = 0;
        while ((rq.size() != 0 || req_ready !== 1'b1) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        n_tests++;
        if (rq.size() != 0 || bq.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d resp and %0d beats still pending, required 0",
                     name, rq.size(), bq.size());
            rq.delete();
            bq.delete();
        end
    endtask

    function automatic beat_t mk(logic [31:0] off, logic [3:0] m, logic [31:0] d);
        beat_t b;
        b.addr  = BASE + off;
        b.wmask = m;
        b.wdata = d;
        return b;
    endfunction

    // Reference: hi1 first, then lo/hi passes until hi stable or retries spent
    task automatic run_read(string name, bit timed);
        logic [31:0] h1;
        logic [31:0] h2;
        logic [31:0] l;
        logic        e;
        int          k;
        clr_model();
        h1 = hi_s[0];
        h2 = '0;
        l  = '0;
        e  = 1'b0;
        bq.push_back(mk(32'hBFFC, 4'h0, 32'h0));
        for (k = 0; k <= MAXR; k++) begin
            l  = lo_s[k];
            h2 = hi_s[k + 1];
            bq.push_back(mk(32'hBFF8, 4'h0, 32'h0));
            bq.push_back(mk(32'hBFFC, 4'h0, 32'h0));
            if (h1 == h2) break;
            if (k == MAXR) begin
                e = 1'b1;
                break;
            end
            h1 = h2;
        end
        issue(OP_RT, 64'h0, {h2, l}, e, timed ? 9 + 6 * k : -1);
        drain(name);
    endtask

    task automatic run_cmp(string name, logic [63:0] wd, bit timed);
        bq.push_back(mk(32'h4000, 4'hF, 32'hFFFF_FFFF));
        bq.push_back(mk(32'h4004, 4'hF, wd[63:32]));
        bq.push_back(mk(32'h4000, 4'hF, wd[31:0]));
        issue(OP_CMP, wd, 64'h0, 1'b0, timed ? 9 : -1);
        drain(name);
    endtask

    task automatic run_msip(string name, logic [63:0] wd, bit timed);
        bq.push_back(mk(32'h0000, 4'b0001, {31'b0, wd[0]}));
        issue(OP_MSIP, wd, 64'h0, 1'b0, timed ? 3 : -1);
        drain(name);
    endtask

    task automatic run_rsv(string name, bit timed);
        int v0;
        v0 = valid_cycles;
        issue(OP_RSV, 64'($urandom), 64'h0, 1'b1, timed ? 1 : -1);
        drain(name);
        check({name, "_no_bus"}, 64'(valid_cycles - v0), 64'h0);
    endtask

    task automatic rand_read(bit timed);
        int n;
        n = $urandom_range(5);
        hi_s[0] = $urandom;
        for (int i = 1; i < 16; i++) hi_s[i] = hi_s[i-1] + ((i <= n) ? 32'd1 : 32'd0);
        for (int i = 0; i < 16; i++) lo_s[i] = $urandom;
        run_read("rand_read", timed);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "tb_clint_host time limit");
    end

    initial begin
        int t;
        for (int i = 0; i < 16; i++) begin
            hi_s[i] = '0;
            lo_s[i] = '0;
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_req_ready", req_ready, 1'b1);
        check("reset_mem_valid", mem_valid, 1'b0);
        check("reset_resp_valid", resp_valid, 1'b0);
        check("reset_outputs", {resp_err, resp_rdata}, 65'h0);
        check("reset_beat_regs", {mem_addr, mem_wmask, mem_wdata}, 68'h0);

        hi_s[0] = 32'h1;
        hi_s[1] = 32'h1;
        lo_s[0] = 32'h42;
        run_read("stable_read", 1'b1);

        hi_s[0] = 32'h0;
        hi_s[1] = 32'h1;
        hi_s[2] = 32'h1;
        lo_s[0] = 32'hFFFF_FFFF;
        lo_s[1] = 32'h0;
        run_read("rollover", 1'b1);

        for (int i = 0; i < 16; i++) hi_s[i] = i;
        for (int i = 0; i < 16; i++) lo_s[i] = 32'hA0 + i;
        run_read("retries_exhausted", 1'b1);

        clr_model();
        mtime_m   = 64'h1_0000_0000;
        irq_watch = 1'b1;
        run_cmp("write_cmp", 64'h0000_0002_8000_0000, 1'b1);
        @(negedge clk);
        irq_watch = 1'b0;
        check("cmp_no_irq", irq_hits, 0);
        check("cmp_final", cmp_m, 64'h0000_0002_8000_0000);

        run_msip("write_msip", 64'h1, 1'b1);
        run_rsv("reserved_op", 1'b1);

        clr_model();
        bq.push_back(mk(32'h4000, 4'hF, 32'hFFFF_FFFF));
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = OP_CMP;
        req_wdata = 64'h0000_0003_0000_0005;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        t = 0;
        while (!(mem_valid && mem_addr == BASE + 32'h4004) && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("reset_reach_cmp_hi", mem_addr, BASE + 32'h4004);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_mem_valid", mem_valid, 1'b0);
        check("midreset_resp_valid", resp_valid, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check("midreset_req_ready", req_ready, 1'b1);
        check("midreset_beats_left", bq.size(), 0);

`ifdef CLINT_HOST_TIMEOUT_EN
        clr_model();
        stuck = 1'b1;
        issue(OP_RT, 64'h0, 64'h0, 1'b1, 256);
        drain("timeout");
        stuck = 1'b0;
        @(negedge clk);
        check("timeout_mem_valid", mem_valid, 1'b0);
`endif

        for (int n = 0; n < 40; n++) begin
            int op;
            bit timed;
            wait_pct = (n % 3 == 0) ? 0 : int'($urandom_range(60));
            timed    = (wait_pct == 0);
            op       = $urandom_range(3);
            case (op)
                0: rand_read(timed);
                1: run_cmp("rand_cmp", {$urandom, $urandom}, timed);
                2: run_msip("rand_msip", 64'($urandom), timed);
                default: run_rsv("rand_rsv", timed);
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
